gpu_launch_ctrl: RTL and testbench
==================================

# gpu_launch_ctrl

Sequencer for one matrix-multiply job on the four-core GPU. It streams operand matrices A and B into the unified RAM through the GPU write port, then writes each core's a0/a1/a2 argument slots. It releases the cores from reset, waits for all cores to report idle, and reads the 16×16 result back out as a word stream. It replaces the free-running init counters and fixed-cycle result dump with a handshaked, restartable job controller that sits between the testbench/host and `Unified_MultiPort_RAM` / `MinimalistCPU` resets.

## Interface
- N_CORES, 4, number of CPU cores sequenced
- N_WORDS, 256, words per matrix (16×16)
- A_BASE, 2048, byte address of matrix A
- B_BASE, 4096, byte address of matrix B
- R_BASE, 6144, byte address of result matrix
- SP_STRIDE, 256, byte stack region per core; core c top = SP_STRIDE*(c+1)
- CORE_SLICE, 256, byte offset between cores' A/result row slices
- RUN_TIMEOUT, 65535, max RUN cycles before error
- CLK in 1 clock, rising edge
- RES_N in 1 async active-low reset
- START in 1 start job (sampled in IDLE only)
- BUSY out 1 high in any state except IDLE
- DONE out 1 one-cycle pulse on job end
- ERR out 1 sticky timeout flag, cleared by next accepted START
- IN_VALID in 1 / IN_READY out 1 / IN_DATA in 32: operand stream, 2*N_WORDS words, A row-major then B row-major
- MEM_WE out 1, MEM_RE out 1, MEM_ADDR out 32, MEM_WDATA out 32, MEM_RDATA in 32: RAM GPU port 0; read data valid the cycle after MEM_RE
- CORE_RES out 1 active-high reset to all cores
- CORE_IDLE in N_CORES per-core IDLE
- OUT_VALID out 1 / OUT_READY in 1 / OUT_DATA out 32: result stream, N_WORDS words row-major

## Operation
- States: IDLE → LOAD → CFG → RUN → RD → CAP → OUT → (RD | FIN) → IDLE; RUN timeout → FIN.
- IDLE: CORE_RES=1. START=1 → LOAD, clear ERR, word counter i=0.
- LOAD: IN_READY=1. Each IN_VALID&IN_READY handshake registers one write: next cycle MEM_WE=1, MEM_ADDR = A_BASE+4i for i<N_WORDS, else B_BASE+4(i−N_WORDS); MEM_WDATA=IN_DATA. After handshake i=2*N_WORDS−1, IN_READY drops the next cycle → CFG.
- CFG: 3*N_CORES consecutive writes, one per cycle. Per core c, in order:
  - a0: addr SP_STRIDE*(c+1)−20, data A_BASE+c*CORE_SLICE
  - a1: addr SP_STRIDE*(c+1)−24, data B_BASE
  - a2: addr SP_STRIDE*(c+1)−28, data R_BASE+c*CORE_SLICE
  - Core 0 goes first. Then → RUN.
- RUN: CORE_RES=0. Run counter starts at 0. CORE_IDLE is ignored for the first 2 RUN cycles. After that, all CORE_IDLE bits high in one cycle → RD with k=0. Counter reaching RUN_TIMEOUT first → ERR=1, FIN; no result read.
- RD: MEM_RE=1, MEM_ADDR=R_BASE+4k, CORE_RES=1 from here on. → CAP.
- CAP: OUT_DATA←MEM_RDATA, OUT_VALID←1. → OUT.
- OUT: hold OUT_DATA/OUT_VALID until OUT_READY. On handshake, OUT_VALID=0 next cycle and k=k+1; → RD if k<N_WORDS−1, else FIN.
- FIN: DONE=1 for one cycle, → IDLE.
- All address arithmetic is 32-bit unsigned with no wrap checking. Counters are sized for 2*N_WORDS and RUN_TIMEOUT.

## Timing
- Reset values (async on RES_N low): state IDLE, BUSY=0, DONE=0, ERR=0, IN_READY=0, MEM_WE=0, MEM_RE=0, MEM_ADDR=0, MEM_WDATA=0, CORE_RES=1, OUT_VALID=0, OUT_DATA=0, counters 0.
- Reset mid-job: immediate return to IDLE with the values above. RAM contents are left as-is.
- START→LOAD: 1 cycle; IN_READY=1 the cycle after START is sampled.
- Write latency: handshake at cycle t → MEM_WE at t+1.
- CFG length: exactly 3*N_CORES cycles of MEM_WE=1.
- Result read: MEM_RE at t, OUT_VALID at t+2. Minimum 3 cycles per word at OUT_READY=1.
- START while BUSY: ignored. IN_VALID outside LOAD: ignored, no RAM write. MEM_WE and MEM_RE are never high together.

## Test plan
- Full job, A=identity, B[i]=i, cores modeled as RAM copy B→R then idle at run cycle 10 → OUT streams 0..255 in order, DONE pulse once, ERR=0.
- IN_VALID toggled every other cycle in LOAD → exactly 512 writes; last B word lands at 4096+1020; no write on gaps.
- CFG check → 12 writes: first addr 236 data 2048; core 3 a2 at addr 996 data 6912; CORE_RES=0 only from RUN entry.
- CORE_IDLE held 4'b1111 throughout → no exit from RUN before run cycle 2. CORE_IDLE=4'b0111 forever with RUN_TIMEOUT=100 → ERR=1 and DONE at ~101 cycles after RUN, OUT_VALID never rises.
- OUT_READY low 20 cycles on word 5 → OUT_DATA/OUT_VALID stable, no further MEM_RE until the handshake.
- RES_N low during RD at k=100 → all outputs at reset values asynchronously. New START → complete job from scratch, 256 words out.

Source files
------------

// File: rtl/gpu_launch_ctrl.sv
// gpu_launch_ctrl
// ---------------
// Sequences one matrix-multiply job on the multi-core GPU:
//   1. streams A then B (row-major) from the operand stream into the unified RAM,
//   2. writes each core's a0/a1/a2 argument slots below its stack top,
//   3. releases the cores from reset and waits for every core to go idle,
//   4. reads the result matrix back out as a handshaked word stream.
// A RUN phase that outlasts RUN_TIMEOUT cycles sets the sticky ERR flag and
// ends the job without reading results.
//
// Ports
//   CLK, RES_N             clock (rising edge), async active-low reset
//   START                  job start, sampled only while idle
//   BUSY, DONE, ERR        status: not idle / one-cycle job end / sticky timeout
//   IN_VALID/READY/DATA    operand stream, 2*N_WORDS words (A then B)
//   MEM_WE/RE/ADDR/WDATA   RAM GPU port 0 (byte addresses)
//   MEM_RDATA              RAM read data, valid the cycle after MEM_RE
//   CORE_RES               active-high reset to all cores
//   CORE_IDLE              per-core idle indication
//   OUT_VALID/READY/DATA   result stream, N_WORDS words row-major
module gpu_launch_ctrl #(
    parameter int unsigned N_CORES     = 4,
    parameter int unsigned N_WORDS     = 256,
    parameter int unsigned A_BASE      = 2048,
    parameter int unsigned B_BASE      = 4096,
    parameter int unsigned R_BASE      = 6144,
    parameter int unsigned SP_STRIDE   = 256,
    parameter int unsigned CORE_SLICE  = 256,
    parameter int unsigned RUN_TIMEOUT = 65535
) (
    input  logic               CLK,
    input  logic               RES_N,
    input  logic               START,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [31:0]        IN_DATA,
    output logic               MEM_WE,
    output logic               MEM_RE,
    output logic [31:0]        MEM_ADDR,
    output logic [31:0]        MEM_WDATA,
    input  logic [31:0]        MEM_RDATA,
    output logic               CORE_RES,
    input  logic [N_CORES-1:0] CORE_IDLE,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [31:0]        OUT_DATA
);

    // One counter serves as load index i, config index j and result index k;
    // size it for the largest of those ranges.
    localparam int unsigned CMAX = (2 * N_WORDS > 3 * N_CORES) ? 2 * N_WORDS : 3 * N_CORES;
    localparam int CW  = $clog2(CMAX + 1);
    localparam int RW  = $clog2(RUN_TIMEOUT + 1);
    localparam int CRW = $clog2(N_CORES + 1);

    localparam logic [31:0] A_B   = 32'(A_BASE);
    localparam logic [31:0] B_B   = 32'(B_BASE);
    localparam logic [31:0] R_B   = 32'(R_BASE);
    localparam logic [31:0] SP_S  = 32'(SP_STRIDE);
    localparam logic [31:0] SLICE = 32'(CORE_SLICE);

    localparam logic [CW-1:0] LOAD_LAST = CW'(2 * N_WORDS - 1);
    localparam logic [CW-1:0] A_WORDS   = CW'(N_WORDS);
    localparam logic [CW-1:0] CFG_END   = CW'(3 * N_CORES);
    localparam logic [CW-1:0] OUT_LAST  = CW'(N_WORDS - 1);
    localparam logic [RW-1:0] RUN_LAST  = RW'(RUN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CFG,
        S_RUN,
        S_RD,
        S_CAP,
        S_OUT,
        S_FIN
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   run_q;
    logic [CRW-1:0]  core_q;
    logic [1:0]      slot_q;

    logic            busy_q, done_q, err_q, in_ready_q;
    logic            mem_we_q, mem_re_q, core_res_q, out_valid_q;
    logic [31:0]     mem_addr_q, mem_wdata_q, out_data_q;

    // Address/data for the next registered access
    logic [31:0]     cnt32, core32, slot32;
    logic [31:0]     load_addr_d, cfg_addr_d, cfg_data_d, rd_next_addr_d;
    logic            all_idle;

    always_comb begin
        cnt32  = 32'(cnt_q);
        core32 = 32'(core_q);
        slot32 = 32'(slot_q);

        // Words 0..N_WORDS-1 are A, the rest are B
        if (cnt_q < A_WORDS) load_addr_d = A_B + (cnt32 << 2);
        else                 load_addr_d = B_B + ((cnt32 - 32'(N_WORDS)) << 2);

        // a0/a1/a2 sit at top-20, top-24, top-28 of each core's stack region
        cfg_addr_d = SP_S * (core32 + 32'd1) - 32'd20 - (slot32 << 2);
        case (slot_q)
            2'd0:    cfg_data_d = A_B + core32 * SLICE;
            2'd1:    cfg_data_d = B_B;
            default: cfg_data_d = R_B + core32 * SLICE;
        endcase

        rd_next_addr_d = R_B + ((cnt32 + 32'd1) << 2);
        all_idle       = &CORE_IDLE;
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            run_q       <= '0;
            core_q      <= '0;
            slot_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_res_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            done_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    core_res_q <= 1'b1;
                    busy_q     <= 1'b0;
                    if (START) begin
                        state_q    <= S_LOAD;
                        busy_q     <= 1'b1;
                        err_q      <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (IN_VALID && in_ready_q) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= load_addr_d;
                        mem_wdata_q <= IN_DATA;
                        if (cnt_q == LOAD_LAST) begin
                            in_ready_q <= 1'b0;
                            cnt_q      <= '0;
                            core_q     <= '0;
                            slot_q     <= '0;
                            state_q    <= S_CFG;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                // The last operand write lands in the first CFG cycle, so the
                // argument writes occupy the following 3*N_CORES cycles and
                // the cores are only released once all of them are in RAM.
                S_CFG: begin
                    if (cnt_q == CFG_END) begin
                        state_q    <= S_RUN;
                        core_res_q <= 1'b0;
                        run_q      <= '0;
                    end else begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cfg_addr_d;
                        mem_wdata_q <= cfg_data_d;
                        cnt_q       <= cnt_q + 1'b1;
                        if (slot_q == 2'd2) begin
                            slot_q <= 2'd0;
                            core_q <= core_q + 1'b1;
                        end else begin
                            slot_q <= slot_q + 2'd1;
                        end
                    end
                end

                // Cores report idle while still coming out of reset, so the
                // first two RUN cycles do not count as completion.
                S_RUN: begin
                    run_q <= run_q + 1'b1;
                    if (run_q >= RW'(2) && all_idle) begin
                        state_q    <= S_RD;
                        core_res_q <= 1'b1;
                        cnt_q      <= '0;
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= R_B;
                    end else if (run_q == RUN_LAST) begin
                        state_q    <= S_FIN;
                        err_q      <= 1'b1;
                        core_res_q <= 1'b1;
                        done_q     <= 1'b1;
                    end
                end

                S_RD: begin
                    state_q <= S_CAP;
                end

                S_CAP: begin
                    out_data_q  <= MEM_RDATA;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end

                S_OUT: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        if (cnt_q == OUT_LAST) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q      <= cnt_q + 1'b1;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= rd_next_addr_d;
                            state_q    <= S_RD;
                        end
                    end
                end

                S_FIN: begin
                    busy_q     <= 1'b0;
                    core_res_q <= 1'b1;
                    state_q    <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign IN_READY  = in_ready_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_RE    = mem_re_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign CORE_RES  = core_res_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;

endmodule

// File: tb/tb_gpu_launch_ctrl.sv
// Directed bench for gpu_launch_ctrl: RAM and core behaviour are modelled
// here; expected addresses/data are computed from the job layout.
module tb_gpu_launch_ctrl;

    logic        CLK = 1'b0;
    logic        RES_N;
    logic        START;
    logic        BUSY, DONE, ERR;
    logic        IN_VALID, IN_READY;
    logic [31:0] IN_DATA;
    logic        MEM_WE, MEM_RE;
    logic [31:0] MEM_ADDR, MEM_WDATA;
    logic [31:0] MEM_RDATA = 32'd0;
    logic        CORE_RES;
    logic [3:0]  CORE_IDLE;
    logic        OUT_VALID, OUT_READY;
    logic [31:0] OUT_DATA;

    gpu_launch_ctrl #(.RUN_TIMEOUT(100)) dut (
        .CLK(CLK), .RES_N(RES_N), .START(START),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .MEM_WE(MEM_WE), .MEM_RE(MEM_RE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
        .CORE_RES(CORE_RES), .CORE_IDLE(CORE_IDLE),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA)
    );

    always #5 CLK = ~CLK;

    // ---------------- RAM / core model and monitors ----------------
    logic [31:0] mem    [0:2047];
    logic [31:0] wlog_a [0:4095];
    logic [31:0] wlog_d [0:4095];
    int wr_cnt = 0, re_cnt = 0, done_cnt = 0, ov_rise = 0, lat_bad = 0;
    int both_hi = 0, low_cnt = 0, run_len = 0;
    int core_mode = 0;  // 0: copy B->R then idle at run cycle 10, 1: always idle, 2: core 3 never idle
    logic ov_prev = 1'b0, re_d1 = 1'b0, re_d2 = 1'b0;

    assign CORE_IDLE = (core_mode == 1) ? 4'b1111 :
                       (core_mode == 2) ? 4'b0111 :
                       ((!CORE_RES && low_cnt >= 10) ? 4'b1111 : 4'b0000);

    always @(posedge CLK) begin
        if (MEM_WE) begin
            mem[MEM_ADDR[12:2]] <= MEM_WDATA;
            wlog_a[wr_cnt]      <= MEM_ADDR;
            wlog_d[wr_cnt]      <= MEM_WDATA;
            wr_cnt              <= wr_cnt + 1;
        end
        if (MEM_RE) begin
            MEM_RDATA <= mem[MEM_ADDR[12:2]];
            re_cnt    <= re_cnt + 1;
        end
        if (MEM_WE && MEM_RE) both_hi <= both_hi + 1;
        if (DONE) done_cnt <= done_cnt + 1;
        // OUT_VALID must rise exactly two cycles after a MEM_RE cycle
        if (OUT_VALID && !ov_prev) begin
            ov_rise <= ov_rise + 1;
            if (!(re_d2 && !re_d1)) lat_bad <= lat_bad + 1;
        end
        ov_prev <= OUT_VALID;
        re_d1   <= MEM_RE;
        re_d2   <= re_d1;
        if (!CORE_RES) low_cnt <= low_cnt + 1;
        else if (low_cnt != 0) begin
            run_len <= low_cnt;
            low_cnt <= 0;
        end
        // A = identity, so the product equals B: cores copy B into R
        if (core_mode == 0 && !CORE_RES && low_cnt == 9)
            for (int i = 0; i < 256; i++) mem[1536 + i] <= mem[1024 + i];
    end

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    function automatic logic [31:0] op_word(input int i);
        if (i < 256) return ((i / 16) == (i % 16)) ? 32'd1 : 32'd0;
        return 32'(i - 256);
    endfunction

    task automatic start_job();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic load(input bit gap);
        int g;
        for (int i = 0; i < 512; i++) begin
            IN_DATA  = op_word(i);
            IN_VALID = 1'b1;
            g = 0;
            while (IN_READY !== 1'b1 && g < 50) begin tick(); g++; end
            if (IN_READY !== 1'b1) begin
                chk("load_ready_timeout", 32'(i), 32'd512);
                IN_VALID = 1'b0;
                return;
            end
            tick();
            if (gap) begin
                IN_VALID = 1'b0;
                IN_DATA  = 32'hDEAD_BEEF;
                tick();
            end
        end
        IN_VALID = 1'b0;
    endtask

    task automatic wait_run();
        int g = 0;
        while (CORE_RES !== 1'b0 && g < 200) begin tick(); g++; end
        if (CORE_RES !== 1'b0) chk("run_entry_timeout", 32'(CORE_RES), 32'd0);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (DONE !== 1'b1 && cyc < 400) begin tick(); cyc++; end
        if (DONE !== 1'b1) chk("done_timeout", 32'(DONE), 32'd1);
    endtask

    task automatic consume(input int n, input int stall_at, output int mism);
        int g;
        logic [31:0] od;
        int r0, unstable;
        mism = 0;
        for (int w = 0; w < n; w++) begin
            g = 0;
            while (OUT_VALID !== 1'b1 && g < 200) begin tick(); g++; end
            if (OUT_VALID !== 1'b1) begin
                chk("out_valid_timeout", 32'(w), 32'(n));
                mism++;
                return;
            end
            if (OUT_DATA !== 32'(w)) mism++;
            if (w == stall_at) begin
                od = OUT_DATA;
                r0 = re_cnt;
                unstable = 0;
                repeat (20) begin
                    tick();
                    if (OUT_VALID !== 1'b1 || OUT_DATA !== od) unstable++;
                end
                chk("stall_stable", 32'(unstable), 32'd0);
                chk("stall_no_re", 32'(re_cnt - r0), 32'd0);
            end
            OUT_READY = 1'b1;
            tick();
            OUT_READY = 1'b0;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w0, d0, o0, r0, m, cyc;
        logic [31:0] ea, ed;

        RES_N = 1'b0; START = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;
        repeat (3) tick();
        chk("rst_flags", {BUSY, DONE, ERR, IN_READY, MEM_WE, MEM_RE, CORE_RES, OUT_VALID}, 8'b0000_0010);
        chk("rst_addr", MEM_ADDR, 32'd0);
        chk("rst_wdata", MEM_WDATA, 32'd0);
        chk("rst_odata", OUT_DATA, 32'd0);
        RES_N = 1'b1;
        tick();

        // IN_VALID while idle must not write
        IN_VALID = 1'b1;
        repeat (3) tick();
        IN_VALID = 1'b0;
        chk("idle_invalid_nowr", 32'(wr_cnt), 32'd0);

        // ---- job 1: gapped load, stall on word 5 ----
        core_mode = 0;
        w0 = wr_cnt; d0 = done_cnt;
        start_job();
        chk("start_busy_ready", {BUSY, IN_READY}, 2'b11);
        load(1'b1);
        wait_run();
        chk("writes_before_run", 32'(wr_cnt - w0), 32'd524);
        m = 0;
        for (int i = 0; i < 512; i++) begin
            ea = (i < 256) ? 32'(2048 + 4 * i) : 32'(4096 + 4 * (i - 256));
            if (wlog_a[w0 + i] !== ea || wlog_d[w0 + i] !== op_word(i)) m++;
        end
        chk("load_log", 32'(m), 32'd0);
        chk("last_b_addr", wlog_a[w0 + 511], 32'd5116);
        chk("last_b_data", wlog_d[w0 + 511], 32'd255);
        m = 0;
        for (int j = 0; j < 12; j++) begin
            ea = 32'(256 * (j / 3 + 1) - 20 - 4 * (j % 3));
            ed = (j % 3 == 0) ? 32'(2048 + 256 * (j / 3)) :
                 (j % 3 == 1) ? 32'd4096 : 32'(6144 + 256 * (j / 3));
            if (wlog_a[w0 + 512 + j] !== ea || wlog_d[w0 + 512 + j] !== ed) m++;
        end
        chk("cfg_log", 32'(m), 32'd0);
        chk("cfg0_addr", wlog_a[w0 + 512], 32'd236);
        chk("cfg0_data", wlog_d[w0 + 512], 32'd2048);
        chk("cfg11_addr", wlog_a[w0 + 523], 32'd996);
        chk("cfg11_data", wlog_d[w0 + 523], 32'd6912);
        // START while busy is ignored
        START = 1'b1; tick(); START = 1'b0;
        consume(256, 5, m);
        chk("job1_stream", 32'(m), 32'd0);
        wait_done(cyc);
        chk("job1_err", 32'(ERR), 32'd0);
        repeat (3) tick();
        chk("job1_done_once", 32'(done_cnt - d0), 32'd1);
        chk("job1_run_len", 32'(run_len), 32'd11);
        chk("job1_idle_after", 32'(BUSY), 32'd0);

        // ---- job 2: cores idle from the start -> RUN lasts 3 cycles ----
        core_mode = 1;
        start_job();
        load(1'b0);
        wait_run();
        consume(256, -1, m);
        chk("job2_stream", 32'(m), 32'd0);
        wait_done(cyc);
        repeat (2) tick();
        chk("job2_run_len", 32'(run_len), 32'd3);

        // ---- job 3: core 3 never idle -> timeout ----
        core_mode = 2;
        o0 = ov_rise; r0 = re_cnt; d0 = done_cnt;
        start_job();
        load(1'b0);
        wait_run();
        wait_done(cyc);
        chk("timeout_cycles", 32'(cyc), 32'd100);
        chk("timeout_err", 32'(ERR), 32'd1);
        repeat (3) tick();
        chk("timeout_err_sticky", 32'(ERR), 32'd1);
        chk("timeout_no_out", 32'(ov_rise - o0), 32'd0);
        chk("timeout_no_re", 32'(re_cnt - r0), 32'd0);
        chk("timeout_run_len", 32'(run_len), 32'd100);
        chk("timeout_done_once", 32'(done_cnt - d0), 32'd1);

        // ---- job 4: reset asserted during RD at k=100 ----
        core_mode = 0;
        start_job();
        chk("err_cleared", 32'(ERR), 32'd0);
        load(1'b0);
        wait_run();
        consume(100, -1, m);
        chk("job4_stream", 32'(m), 32'd0);
        chk("rd_k100", {MEM_RE, MEM_ADDR}, {1'b1, 32'd6544});
        #2 RES_N = 1'b0;
        #1;
        chk("midrst_flags", {BUSY, DONE, ERR, IN_READY, MEM_WE, MEM_RE, CORE_RES, OUT_VALID}, 8'b0000_0010);
        chk("midrst_addr", MEM_ADDR, 32'd0);
        chk("midrst_odata", OUT_DATA, 32'd0);
        tick();
        RES_N = 1'b1;
        tick();

        // ---- job 5: full job after reset ----
        d0 = done_cnt;
        start_job();
        load(1'b0);
        wait_run();
        consume(256, -1, m);
        chk("job5_stream", 32'(m), 32'd0);
        wait_done(cyc);
        repeat (2) tick();
        chk("job5_done_once", 32'(done_cnt - d0), 32'd1);
        chk("job5_err", 32'(ERR), 32'd0);

        chk("never_we_and_re", 32'(both_hi), 32'd0);
        chk("re_to_valid_latency", 32'(lat_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
